tm1640_frame_seq: RTL
=====================

// Module: tm1640_frame_seq
// PURPOSE
//  Parametrised frame sequencer for TM1640 LED displays. Snapshots NUM_DIGITS hex
//  digits, decimal points, blanking and brightness; encodes them to 7-segment patterns;
//  streams the full TM1640 command frame byte-by-byte into the tm1640 byte driver over
//  its latch/byte/end/busy handshake. Supports on-demand updates, optional power-up
//  frame and periodic auto-refresh. Sits between user logic and the tm1640 instance.
// PARAMETERS
//  NUM_DIGITS     9   digits per frame, 1..16; START_ADDR+NUM_DIGITS>16 is an elaboration error
//  START_ADDR     0   first TM1640 grid address, 0..15
//  POWERUP_FRAME  1   1: send one frame automatically after reset release
//  AUTO_REFRESH   0   0: off; N>0: restart a frame N clk cycles after each done
// PORTS
//  clk         in   1              system clock
//  rst         in   1              reset, asynchronous, active-high
//  digits      in   4*NUM_DIGITS   hex value per digit; digit k at [4k+3:4k]; digit 0 at START_ADDR
//  dp          in   NUM_DIGITS     decimal point per digit (segment bit 7)
//  blank       in   NUM_DIGITS     1: digit k sends 0x00 (overrides digit value and dp)
//  brightness  in   3              TM1640 pulse-width code 0..7
//  disp_on     in   1              display on/off bit in command 3
//  update      in   1              1-cycle request to send a frame
//  busy        out  1              frame in progress
//  done        out  1              1-cycle pulse after the last byte of a frame completes
//  tm_latch    out  1              to driver: byte valid
//  tm_byte     out  8              to driver: byte to send
//  tm_end      out  1              to driver: stop condition after this byte
//  tm_busy     in   1              from driver: transfer in progress
// BEHAVIOUR
//  Reset (async, immediate): busy=0, done=0, tm_latch=0, tm_byte=0x00, tm_end=0,
//   state=IDLE, pending=0, refresh counter=0. Reset mid-frame abandons the frame; the
//   driver shares rst.
//  States: IDLE -> LOAD -> CMD1 -> CMD2 -> DATA(xNUM_DIGITS) -> CMD3 -> DONE -> IDLE.
//  Trigger in IDLE: update=1, or first cycle after reset with POWERUP_FRAME=1, or refresh
//   counter expiry. Cycle T trigger -> T+1 LOAD (busy=1, snapshot of digits/dp/blank/
//   brightness/disp_on) -> T+2 first tm_latch=1.
//  Bytes: CMD1=0x40 end=1 (write data, auto-increment); CMD2=0xC0|START_ADDR end=0;
//   DATA k=seg(k) in ascending k, end=1 only on k=NUM_DIGITS-1; CMD3=0x88|brightness
//   when disp_on=1, 0x80|brightness when 0; end=1.
//  Per-byte handshake: ISSUE drives tm_byte/tm_end and tm_latch=1, and holds them until
//   tm_busy=1 is sampled. tm_latch drops the next cycle; tm_byte/tm_end stay stable.
//   The next byte issues on the first cycle tm_busy=0 is sampled after that. No byte
//   issues while tm_busy=1.
//  seg(k): blank[k]=1 -> 0x00; else {dp[k], lut(digits[k])}. lut 0-F: 3F 06 5B 4F 66 6D 7D
//   07 7F 6F 77 7C 39 5E 79 71 (bit0=a .. bit6=g).
//  DONE: done=1 for exactly one cycle, busy=0 in the same cycle, state returns to IDLE.
//  update while busy: sets pending. Multiple requests coalesce to one. The current frame
//   finishes unchanged from its snapshot. Pending starts a new frame from IDLE on the
//   cycle after DONE, with a fresh snapshot. update coincident with DONE also sets pending.
//  Input changes without update have no effect. An in-flight frame never tears.
//  AUTO_REFRESH: counter clears at DONE and counts in IDLE. At count AUTO_REFRESH-1 it
//   triggers. An update or pending trigger in IDLE takes priority and clears the counter.
// TESTING
//  1 Reset release, POWERUP_FRAME=1, digits=0x987654321, dp=0, blank=0, bright=7, on=1 ->
//    bytes 40 C0 06 5B 4F 66 6D 7D 07 7F 6F 8F; tm_end=1 on 40, 6F, 8F only; one done pulse.
//  2 update with digits[3:0]=0xA, dp[0]=1, blank[1]=1 -> DATA0=0xF7, DATA1=0x00.
//  3 Three update pulses during a frame, digits changed mid-frame -> current frame keeps
//    old data; exactly one extra frame with new data; two done pulses total.
//  4 Driver model stretches tm_busy 50 cycles per byte -> tm_latch drops 1 cycle after
//    tm_busy rises; no latch while tm_busy=1.
//  5 Assert rst during DATA byte 4 -> all outputs 0 same cycle. After release with
//    POWERUP_FRAME=1, a full new frame starts at CMD1.
//  6 AUTO_REFRESH=100, no updates -> frames restart 100 cycles after each done;
//    disp_on=0, bright=2 -> CMD3=0x82.

Source files
------------

// File: rtl/tm1640_frame_seq_if.sv
// Byte-level handshake between the frame sequencer and the tm1640 serial byte driver.
interface tm1640_frame_seq_if;
  logic       tm_latch;
  logic [7:0] tm_byte;
  logic       tm_end;
  logic       tm_busy;

  modport master (output tm_latch, output tm_byte, output tm_end, input tm_busy);
  modport slave  (input tm_latch, input tm_byte, input tm_end, output tm_busy);
endinterface

// File: rtl/tm1640_frame_seq.sv
// Snapshots digits/dp/blank/brightness and streams a full TM1640 frame into the byte driver.
// First byte latches 2 cycles after a trigger; each byte waits for the driver's busy to rise then fall.
module tm1640_frame_seq #(
  parameter int NUM_DIGITS    = 9,
  parameter int START_ADDR    = 0,
  parameter int POWERUP_FRAME = 1,
  parameter int AUTO_REFRESH  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [2:0]              brightness,
  input  logic                    disp_on,
  input  logic                    update,
  output logic                    busy,
  output logic                    done,
  tm1640_frame_seq_if.master      tm
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || START_ADDR < 0 || START_ADDR > 15 ||
        START_ADDR + NUM_DIGITS > 16) begin : g_bad_cfg
      $error("tm1640_frame_seq: digit window does not fit in the 16 grid addresses");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOAD, CMD1, CMD2, DATA, CMD3, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    wait_q, wait_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0]   dp_q, blank_q;
  logic [2:0]              bright_q;
  logic                    on_q;
  logic                    pend_q, pwr_q;
  logic                    ref_hit, trig, adv, last;
  logic [7:0]              seg_k;

  function automatic logic [6:0] lut7(input logic [3:0] v);
    case (v)
      4'h0: lut7 = 7'h3F;  4'h1: lut7 = 7'h06;  4'h2: lut7 = 7'h5B;  4'h3: lut7 = 7'h4F;
      4'h4: lut7 = 7'h66;  4'h5: lut7 = 7'h6D;  4'h6: lut7 = 7'h7D;  4'h7: lut7 = 7'h07;
      4'h8: lut7 = 7'h7F;  4'h9: lut7 = 7'h6F;  4'hA: lut7 = 7'h77;  4'hB: lut7 = 7'h7C;
      4'hC: lut7 = 7'h39;  4'hD: lut7 = 7'h5E;  4'hE: lut7 = 7'h79;  default: lut7 = 7'h71;
    endcase
  endfunction

  assign trig  = update | pend_q | pwr_q | ref_hit;
  assign last  = (idx_q == IW'(NUM_DIGITS - 1));
  assign seg_k = blank_q[idx_q] ? 8'h00 : {dp_q[idx_q], lut7(dig_q[4*idx_q +: 4])};

  // wait_q splits every byte state into issue (latch high) and wait-for-driver-idle halves
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    idx_d        = idx_q;
    adv          = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    tm.tm_latch  = 1'b0;
    tm.tm_byte   = 8'h00;
    tm.tm_end    = 1'b0;
    if (state_q inside {CMD1, CMD2, DATA, CMD3}) begin
      tm.tm_latch = !wait_q;
      if (!wait_q && tm.tm_busy) wait_d = 1'b1;
      if (wait_q && !tm.tm_busy) begin
        wait_d = 1'b0;
        adv    = 1'b1;
      end
    end
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (trig) state_d = LOAD;
      end
      LOAD: state_d = CMD1;
      CMD1: begin
        tm.tm_byte = 8'h40;
        tm.tm_end  = 1'b1;
        if (adv) state_d = CMD2;
      end
      CMD2: begin
        tm.tm_byte = 8'hC0 | 8'(START_ADDR);
        if (adv) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        tm.tm_byte = seg_k;
        tm.tm_end  = last;
        if (adv) begin
          if (last) state_d = CMD3;
          else      idx_d   = idx_q + 1'b1;
        end
      end
      CMD3: begin
        tm.tm_byte = {4'b1000, on_q, bright_q};
        tm.tm_end  = 1'b1;
        if (adv) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
    end
  end

  // Snapshot is taken on the trigger edge so the whole frame comes from one set of inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q    <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      bright_q <= 3'd0;
      on_q     <= 1'b0;
    end else if (state_q == IDLE && trig) begin
      dig_q    <= digits;
      dp_q     <= dp;
      blank_q  <= blank;
      bright_q <= brightness;
      on_q     <= disp_on;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      pwr_q  <= (POWERUP_FRAME != 0);
    end else begin
      if (state_q == IDLE) begin
        pwr_q  <= 1'b0;
        pend_q <= 1'b0;
      end else if (update) begin
        pend_q <= 1'b1;
      end
    end
  end

  generate
    if (AUTO_REFRESH > 0) begin : g_refresh
      localparam int CW = (AUTO_REFRESH > 1) ? $clog2(AUTO_REFRESH) : 1;
      logic [CW-1:0] cnt_q;
      assign ref_hit = (state_q == IDLE) && (cnt_q == CW'(AUTO_REFRESH - 1));
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         cnt_q <= '0;
        else if (state_q == DONE || (state_q == IDLE && trig)) cnt_q <= '0;
        else if (state_q == IDLE)                        cnt_q <= cnt_q + 1'b1;
      end
    end else begin : g_no_refresh
      assign ref_hit = 1'b0;
    end
  endgenerate

endmodule
